// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Routes core loads/stores to on-chip RAM, a req/ack IO window
//            with timeout, or unmapped space (error pulse).
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
   parameter int          RAM_WORDS  = 1024,
   parameter logic [31:0] IO_BASE    = 32'h0001_0000,
   parameter int          IO_SIZE    = 256,
   parameter int          IO_TIMEOUT = 16,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write_enable,
   input  logic                         read_enable,
   input  logic [31:0]                  WriteAddress,
   input  logic [31:0]                  WriteData,
   output logic [31:0]                  ReadData,
   output logic                         stall,
   output logic                         bus_error,
   output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
   output logic [31:0]                  ram_wdata,
   output logic                         ram_wren,
   input  logic [31:0]                  ram_rdata,
   output logic                         io_req,
   output logic                         io_we,
   output logic [31:0]                  io_addr,
   output logic [31:0]                  io_wdata,
   input  logic                         io_ack,
   input  logic [31:0]                  io_rdata
);

   localparam int                 c_ram_aw   = $clog2(RAM_WORDS);
   localparam int                 c_cnt_w    = $clog2(IO_TIMEOUT) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(IO_TIMEOUT - 1);
   localparam logic [32:0]        c_ram_end  = 33'(RAM_WORDS) << 2;
   localparam logic [32:0]        c_io_lo    = {1'b0, IO_BASE};
   localparam logic [32:0]        c_io_hi    = {1'b0, IO_BASE} + 33'(IO_SIZE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_IO   = 2'd2,
      SRC_ZERO = 2'd3
   } src_t;

   state_t             r_state, w_next_state;
   src_t               r_src, w_next_src;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_rd;
   logic               r_bus_error, w_bus_error_next;
   logic               r_io_we;
   logic [31:0]        r_io_addr, r_io_wdata;

   logic [32:0]        w_addr33;
   logic               w_access, w_read, w_ram_hit, w_io_hit, w_timeout;

   // Compare in 33 bits so a window ending at 4 GiB cannot wrap.
   assign w_addr33  = {1'b0, WriteAddress};
   assign w_access  = write_enable | read_enable;
   assign w_read    = read_enable & ~write_enable;
   assign w_ram_hit = w_addr33 < c_ram_end;
   assign w_io_hit  = ~w_ram_hit & (w_addr33 >= c_io_lo) & (w_addr33 < c_io_hi);
   assign w_timeout = (r_state == S_REQ) & ~io_ack & (r_cnt == c_cnt_last);

   always_comb begin
      w_next_state     = r_state;
      w_next_src       = SRC_NONE;
      w_bus_error_next = 1'b0;
      stall            = 1'b0;
      io_req           = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               if (w_ram_hit) begin
                  if (w_read) w_next_src = SRC_RAM;
               end else if (w_io_hit) begin
                  stall        = ~reset;
                  w_next_state = S_REQ;
               end else begin
                  w_bus_error_next = 1'b1;
                  if (w_read) w_next_src = SRC_ZERO;
               end
            end
         end
         S_REQ: begin
            io_req           = 1'b1;
            stall            = 1'b1;
            w_bus_error_next = w_timeout;
            if (io_ack || w_timeout) w_next_state = S_DONE;
         end
         S_DONE: begin
            // Completion cycle: the core's unchanged inputs are not decoded again.
            w_next_state = S_IDLE;
            if (!r_io_we) w_next_src = SRC_IO;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_src       <= SRC_NONE;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_bus_error <= 1'b0;
         r_io_we     <= 1'b0;
         r_io_addr   <= '0;
         r_io_wdata  <= '0;
      end else begin
         r_state     <= w_next_state;
         r_src       <= w_next_src;
         r_bus_error <= w_bus_error_next;
         case (r_state)
            S_IDLE: begin
               if (w_access && w_io_hit) begin
                  r_io_addr  <= {WriteAddress[31:2], 2'b00};
                  r_io_wdata <= WriteData;
                  r_io_we    <= write_enable;
                  r_cnt      <= '0;
               end
            end
            S_REQ: begin
               if (io_ack) begin
                  if (!r_io_we) r_rd <= io_rdata;
               end else if (w_timeout) begin
                  r_rd <= ERR_DATA;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ReadData = '0;
      case (r_src)
         SRC_RAM: ReadData = ram_rdata;
         SRC_IO:  ReadData = r_rd;
         default: ReadData = '0;
      endcase
   end

   assign ram_addr  = WriteAddress[2 +: c_ram_aw];
   assign ram_wdata = WriteData;
   assign ram_wren  = write_enable & w_ram_hit & ~reset & (r_state == S_IDLE);
   assign bus_error = r_bus_error;
   assign io_we     = r_io_we;
   assign io_addr   = r_io_addr;
   assign io_wdata  = r_io_wdata;

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sits directly downstream of the pipelined `arm` core's memory port (`write_enable` / `WriteAddress` / `WriteData` / `ReadData`).
- Decodes each MEM-stage access into three targets:
  - on-chip synchronous RAM (fixed latency, never stalls);
  - a memory-mapped IO window (camera and peripherals) reached over a req/ack handshake with timeout;
  - unmapped space, which raises an error.
- Drives `stall` back to the core while an IO transaction is outstanding.

Parameters:
- RAM_WORDS, 1024, depth of on-chip RAM in 32-bit words; RAM region is byte addresses 0 .. RAM_WORDS*4-1.
- IO_BASE, 32'h0001_0000, first byte address of the IO window.
- IO_SIZE, 256, IO window size in bytes.
- IO_TIMEOUT, 16, maximum cycles spent in REQ before the transaction is aborted.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an IO timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_enable  in  1  core store strobe.
- read_enable  in  1  core load strobe (MEM-stage MemtoReg).
- WriteAddress  in  32  byte address of the access, loads and stores.
- WriteData  in  32  store data.
- ReadData  out  32  load data to the core.
- stall  out  1  freezes the core pipeline.
- bus_error  out  1  one-cycle error pulse.
- ram_addr  out  $clog2(RAM_WORDS)  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rdata  in  32  RAM read data; 1-cycle latency after ram_addr.
- io_req  out  1  IO request, held until ack or timeout.
- io_we  out  1  IO write (1) or read (0).
- io_addr  out  32  IO byte address, word-aligned.
- io_wdata  out  32  IO write data.
- io_ack  in  1  IO completion; sampled on the rising edge.
- io_rdata  in  32  IO read data, valid with io_ack.

Behaviour:
- Access definitions:
  - An access is any cycle with write_enable or read_enable high.
  - If both are high, the access is a write and no read data is produced.
  - Address bits [1:0] are ignored; every access is an aligned word.
- Decode priority is RAM, then IO, then unmapped.
- RAM path is combinational pass-through:
  - ram_addr = WriteAddress[2 +: width].
  - ram_wdata = WriteData.
  - ram_wren = write_enable & ram_hit & ~reset & (fsm == IDLE).
- Source register `src` is one of {NONE, RAM, IO, ZERO}:
  - Updated each edge with the source of the read that completed that cycle; NONE otherwise.
  - ReadData mux: RAM → ram_rdata; IO → rd_reg; ZERO or NONE → 0.
  - Load data is therefore valid exactly one cycle after the completion cycle, for all targets.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - An IO-hit access asserts stall combinationally.
    - On the next edge: go to REQ; latch io_addr, io_wdata, io_we; clear the timeout counter.
    - RAM and unmapped accesses complete in IDLE with stall = 0.
  - REQ:
    - io_req = 1 and stall = 1.
    - On an edge with io_ack: rd_reg <= io_rdata (reads only), then go to DONE.
    - On an edge without ack where the counter equals IO_TIMEOUT-1: rd_reg <= ERR_DATA, bus_error pulses in the DONE cycle, go to DONE.
    - Otherwise the counter increments.
  - DONE:
    - stall = 0, io_req = 0; this is the completion cycle.
    - The core's inputs, still showing the same access, are not decoded again.
    - Go to IDLE on the next edge.
- Unmapped access:
  - The write is dropped and a read returns 0 (src = ZERO).
  - bus_error pulses the cycle after the access; no stall.
- Minimum IO stall is 2 cycles (ack in the first REQ cycle); maximum is IO_TIMEOUT+1.
- An io_ack outside REQ is ignored.
- Reset values (asynchronous):
  - State: fsm = IDLE, counter = 0, rd_reg = 0, src = NONE.
  - Outputs: ReadData = 0, stall = 0, bus_error = 0, io_req = 0, io_we = 0, io_addr = 0, io_wdata = 0, ram_wren = 0.
- Reset asserted mid-REQ aborts the transaction immediately; no retry after reset is released.

Test Plan:
- Store 32'h1234_5678 to 0x10, then load 0x10 → ram_wren for one cycle; ReadData = 32'h1234_5678 one cycle after the load; stall never asserts.
- Load 0x0001_0004 with io_ack in the 3rd REQ cycle and io_rdata = 32'hCAFE_0001 → stall high for 4 cycles, io_addr = 0x0001_0004, io_we = 0; ReadData = 32'hCAFE_0001 the cycle after DONE.
- IO store with io_ack never asserted → io_req high for exactly 16 cycles; bus_error pulses once; stall releases; no RAM write occurs.
- Load 0x0008_0000 (unmapped) → no stall; ReadData = 0 next cycle; bus_error pulse one cycle after the access.
- Assert reset in the 2nd REQ cycle, then raise io_ack after release → io_req and stall drop asynchronously; fsm = IDLE; the late ack does not change ReadData (stays 0).
- Both write_enable and read_enable high at RAM 0x20 with WriteData = 5 → RAM written with 5; ReadData = 0 (src NONE) the next cycle.
